// File: rtl/thor2023_icache_fill_ctrl_if.sv
// Signal bundle between the icache fill controller, the fetch unit, the tag array and the bus interface unit.
interface thor2023_icache_fill_ctrl_if #(
    parameter int LINES  = 256,
    parameter int WAYS   = 4,
    parameter int TAGBIT = 14,
    parameter int ADRW   = 32,
    parameter int BEATS  = 4
);
    localparam int NDXW  = $clog2(LINES);
    localparam int TAGW  = ADRW - TAGBIT;
    localparam int BEATW = $clog2(BEATS);

    logic                 req_i;
    logic [ADRW-1:0]      adr_i;
    logic                 inv_i;
    logic [NDXW-1:0]      ndx_o;
    logic [WAYS*TAGW-1:0] tag_i;
    logic                 ack_o;
    logic [1:0]           way_o;
    logic                 busy_o;
    logic                 mem_req_o;
    logic [ADRW-1:0]      mem_adr_o;
    logic                 mem_ack_i;
    logic                 dat_we_o;
    logic [BEATW-1:0]     beat_o;
    logic                 tag_wr_o;
    logic [1:0]           tag_way_o;
    logic [ADRW-1:0]      tag_adr_o;

    modport master (
        input  req_i, adr_i, inv_i, tag_i, mem_ack_i,
        output ndx_o, ack_o, way_o, busy_o, mem_req_o, mem_adr_o,
               dat_we_o, beat_o, tag_wr_o, tag_way_o, tag_adr_o
    );

    modport slave (
        output req_i, adr_i, inv_i, tag_i, mem_ack_i,
        input  ndx_o, ack_o, way_o, busy_o, mem_req_o, mem_adr_o,
               dat_we_o, beat_o, tag_wr_o, tag_way_o, tag_adr_o
    );
endinterface

// File: rtl/thor2023_icache_fill_ctrl.sv
// Instruction-cache tag lookup, victim selection and multi-beat line fill sequencer (4-way).
module thor2023_icache_fill_ctrl #(
    parameter int LINES  = 256,
    parameter int WAYS   = 4,
    parameter int LOBIT  = 6,
    parameter int TAGBIT = 14,
    parameter int ADRW   = 32,
    parameter int BEATS  = 4
) (
    input  logic clk,
    input  logic rst,
    thor2023_icache_fill_ctrl_if.master bus
);
    localparam int NDXW  = $clog2(LINES);
    localparam int TAGW  = ADRW - TAGBIT;
    localparam int BEATW = $clog2(BEATS);
    localparam int BOFF  = LOBIT - BEATW;
    localparam logic [ADRW-1:0] OFFMASK = ADRW'((1 << LOBIT) - 1);

    typedef enum logic [1:0] {IDLE, FILL, TAGWR} state_t;

    state_t                       state_q, state_d;
    logic [LINES-1:0][WAYS-1:0]   valid_q;
    logic [1:0]                   rr_q;
    logic                         ack_q, ack_d;
    logic [1:0]                   way_q, way_d;
    logic [1:0]                   victim_q;
    logic                         use_rr_q;
    logic [BEATW-1:0]             beat_q;
    logic [ADRW-1:0]              line_adr_q;
    logic                         inv_pend_q;

    logic [NDXW-1:0]              ndx;
    logic [NDXW-1:0]              line_ndx;
    logic [WAYS-1:0]              hit;
    logic [WAYS-1:0]              free;
    logic [1:0]                   hit_way;
    logic [1:0]                   free_way;
    logic                         lookup_miss;

    assign ndx      = bus.adr_i[LOBIT+NDXW-1:LOBIT];
    assign line_ndx = line_adr_q[LOBIT+NDXW-1:LOBIT];

    // Lowest-index way wins for both hit selection and free-way victim choice.
    always_comb begin
        hit      = '0;
        free     = ~valid_q[ndx];
        hit_way  = 2'd0;
        free_way = 2'd0;
        for (int w = 0; w < WAYS; w++) begin
            hit[w] = valid_q[ndx][w] && (bus.tag_i[w*TAGW +: TAGW] == bus.adr_i[ADRW-1:TAGBIT]);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (hit[w])  hit_way  = 2'(w);
            if (free[w]) free_way = 2'(w);
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        way_d       = way_q;
        lookup_miss = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i && !bus.inv_i) begin
                    if (|hit) begin
                        ack_d = 1'b1;
                        way_d = hit_way;
                    end else begin
                        lookup_miss = 1'b1;
                        state_d     = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.mem_ack_i && beat_q == BEATW'(BEATS - 1)) state_d = TAGWR;
            end
            TAGWR: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                way_d   = victim_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            rr_q       <= 2'd0;
            ack_q      <= 1'b0;
            way_q      <= 2'd0;
            victim_q   <= 2'd0;
            use_rr_q   <= 1'b0;
            beat_q     <= '0;
            line_adr_q <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            way_q   <= way_d;
            if (lookup_miss) begin
                line_adr_q <= bus.adr_i & ~OFFMASK;
                victim_q   <= (|free) ? free_way : rr_q;
                use_rr_q   <= ~|free;
                beat_q     <= '0;
            end
            if (state_q == FILL && bus.mem_ack_i) beat_q <= beat_q + 1'b1;
            if (state_q != IDLE && bus.inv_i) inv_pend_q <= 1'b1;
            if (state_q == IDLE && bus.inv_i) valid_q <= '0;
            // An invalidate seen during the fill wins over installing the new line.
            if (state_q == TAGWR) begin
                inv_pend_q <= 1'b0;
                if (inv_pend_q || bus.inv_i) valid_q <= '0;
                else                         valid_q[line_ndx][victim_q] <= 1'b1;
                if (use_rr_q) rr_q <= rr_q + 2'd1;
            end
        end
    end

    assign bus.ndx_o     = ndx;
    assign bus.ack_o     = ack_q;
    assign bus.way_o     = way_q;
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.mem_req_o = (state_q == FILL);
    assign bus.mem_adr_o = line_adr_q | (ADRW'(beat_q) << BOFF);
    assign bus.dat_we_o  = (state_q == FILL) && bus.mem_ack_i;
    assign bus.beat_o    = beat_q;
    assign bus.tag_wr_o  = (state_q == TAGWR);
    assign bus.tag_way_o = victim_q;
    assign bus.tag_adr_o = line_adr_q;
endmodule

// File: tb/tb_thor2023_icache_fill_ctrl.sv
// Directed bench for the icache fill controller: hits, fills, victim choice, invalidate and reset cases.
module tb_thor2023_icache_fill_ctrl;
    logic clk;
    logic rst;
    int   nchk;
    int   nerr;

    thor2023_icache_fill_ctrl_if ifc ();

    thor2023_icache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] pack4(input int t0, input int t1, input int t2, input int t3);
        return {18'(t3), 18'(t2), 18'(t1), 18'(t0)};
    endfunction

    // Request must already be driven; runs the miss through all beats and the ack cycle.
    task automatic fill(input logic [31:0] a, input logic [1:0] vw, input int inv_beat);
        logic [31:0] base;
        base = a & ~32'h3F;
        tick();
        chk("miss_busy", 32'(ifc.busy_o), 32'd1);
        chk("miss_memreq", 32'(ifc.mem_req_o), 32'd1);
        ifc.mem_ack_i = 1'b0;
        #1;
        chk("fill_wait_adr", ifc.mem_adr_o, base);
        chk("fill_wait_we", 32'(ifc.dat_we_o), 32'd0);
        tick();
        chk("fill_wait_beat", 32'(ifc.beat_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            ifc.mem_ack_i = 1'b1;
            ifc.inv_i     = (b == inv_beat);
            #1;
            chk("fill_adr", ifc.mem_adr_o, base + 32'(b * 16));
            chk("fill_we", 32'(ifc.dat_we_o), 32'd1);
            chk("fill_beat", 32'(ifc.beat_o), 32'(b));
            tick();
        end
        ifc.mem_ack_i = 1'b0;
        ifc.inv_i     = 1'b0;
        chk("tagwr_en", 32'(ifc.tag_wr_o), 32'd1);
        chk("tagwr_way", 32'(ifc.tag_way_o), 32'(vw));
        chk("tagwr_adr", ifc.tag_adr_o, base);
        chk("tagwr_memreq", 32'(ifc.mem_req_o), 32'd0);
        chk("tagwr_ack", 32'(ifc.ack_o), 32'd0);
        tick();
        chk("fill_ack", 32'(ifc.ack_o), 32'd1);
        chk("fill_way", 32'(ifc.way_o), 32'(vw));
        chk("fill_idle", 32'(ifc.busy_o), 32'd0);
        chk("fill_tagwr_off", 32'(ifc.tag_wr_o), 32'd0);
        ifc.req_i = 1'b0;
        tick();
        chk("fill_ack_pulse", 32'(ifc.ack_o), 32'd0);
    endtask

    task automatic hit(input logic [31:0] a, input logic [1:0] w);
        ifc.req_i = 1'b1;
        ifc.adr_i = a;
        tick();
        chk("hit_ack", 32'(ifc.ack_o), 32'd1);
        chk("hit_way", 32'(ifc.way_o), 32'(w));
        chk("hit_nomem", 32'(ifc.mem_req_o), 32'd0);
        chk("hit_idle", 32'(ifc.busy_o), 32'd0);
        ifc.req_i = 1'b0;
        tick();
        chk("hit_ack_pulse", 32'(ifc.ack_o), 32'd0);
    endtask

    initial begin
        nchk          = 0;
        nerr          = 0;
        rst           = 1'b1;
        ifc.req_i     = 1'b0;
        ifc.adr_i     = '0;
        ifc.inv_i     = 1'b0;
        ifc.tag_i     = '0;
        ifc.mem_ack_i = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(ifc.busy_o), 32'd0);
        chk("rst_ack", 32'(ifc.ack_o), 32'd0);
        chk("rst_memreq", 32'(ifc.mem_req_o), 32'd0);
        chk("rst_tagwr", 32'(ifc.tag_wr_o), 32'd0);
        chk("rst_beat", 32'(ifc.beat_o), 32'd0);
        chk("rst_way", 32'(ifc.way_o), 32'd0);
        chk("rst_tagway", 32'(ifc.tag_way_o), 32'd0);
        chk("rst_tagadr", ifc.tag_adr_o, 32'd0);
        rst = 1'b0;

        // First miss into an empty set lands in way 0.
        ifc.req_i = 1'b1;
        ifc.adr_i = 32'h0000_1040;
        #1;
        chk("ndx", 32'(ifc.ndx_o), 32'h41);
        fill(32'h0000_1040, 2'd0, -1);
        hit(32'h0000_1048, 2'd0);

        // Populate the remaining ways of set 0x41; matching tags in invalid ways must not hit.
        ifc.tag_i = pack4(0, 1, 2, 3);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_5040; fill(32'h0000_5040, 2'd1, -1);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_9040; fill(32'h0000_9040, 2'd2, -1);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_D040; fill(32'h0000_D040, 2'd3, -1);
        hit(32'h0000_D040, 2'd3);

        // Full set: round-robin victims 0 then 1.
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0001_1040; fill(32'h0001_1040, 2'd0, -1);
        ifc.tag_i = pack4(4, 1, 2, 3);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0001_5040; fill(32'h0001_5040, 2'd1, -1);

        // Duplicate matching tags: lowest way wins.
        ifc.tag_i = pack4(1, 1, 2, 3);
        hit(32'h0000_5040, 2'd0);

        // Invalidate together with a request: request held off, then misses.
        ifc.tag_i = pack4(0, 0, 0, 0);
        ifc.req_i = 1'b1;
        ifc.adr_i = 32'h0000_1040;
        ifc.inv_i = 1'b1;
        tick();
        ifc.inv_i = 1'b0;
        chk("inv_prio_ack", 32'(ifc.ack_o), 32'd0);
        chk("inv_prio_busy", 32'(ifc.busy_o), 32'd0);
        fill(32'h0000_1040, 2'd0, -1);

        // Invalidate during beat 2: data delivered but line not retained.
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_2040; fill(32'h0000_2040, 2'd0, 2);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_2040; fill(32'h0000_2040, 2'd0, -1);

        // Stray bus ack in IDLE is ignored.
        ifc.mem_ack_i = 1'b1;
        #1;
        chk("idle_ack_we", 32'(ifc.dat_we_o), 32'd0);
        tick();
        ifc.mem_ack_i = 1'b0;
        chk("idle_ack_beat", 32'(ifc.beat_o), 32'd0);
        chk("idle_ack_busy", 32'(ifc.busy_o), 32'd0);

        // Reset after beat 1 ack abandons the fill.
        ifc.req_i = 1'b1;
        ifc.adr_i = 32'h0000_3040;
        tick();
        ifc.mem_ack_i = 1'b1;
        tick();
        tick();
        chk("pre_rst_beat", 32'(ifc.beat_o), 32'd2);
        rst           = 1'b1;
        ifc.mem_ack_i = 1'b0;
        ifc.req_i     = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_busy", 32'(ifc.busy_o), 32'd0);
        chk("midrst_memreq", 32'(ifc.mem_req_o), 32'd0);
        chk("midrst_ack", 32'(ifc.ack_o), 32'd0);
        chk("midrst_beat", 32'(ifc.beat_o), 32'd0);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_3040; fill(32'h0000_3040, 2'd0, -1);
        ifc.req_i = 1'b1; ifc.adr_i = 32'h0000_1040; fill(32'h0000_1040, 2'd0, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
